mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported unified instruction/data memory between two requesters. Port 0 is the multicycle CPU's fetch/load/store path (the address that today comes from the IorD mux). Port 1 is a loader/debug master that writes program images and inspects memory. The block sits between both masters and the memory. It runs a small grant state machine with a req/gnt handshake and a registered read-valid return. Arbitration is fixed priority by default, or round-robin when configured.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/arb_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port unified-memory arbiter.
// Optional round-robin tie-break is enabled with MEM_ARB_RR_EN.
package mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between the two requesters.
// Masked ports are ineligible; a tie goes to the port not granted last.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       last,
  output logic       winner,
  output logic       valid
);

  logic [1:0] elig;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    elig   = req & ~mask;
    valid  = |elig;
    winner = PORT_CPU;
    if (elig == 2'b11) begin
      winner = ~last;
    end else if (elig[1]) begin
      winner = PORT_DBG;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported instruction/data memory between the CPU (port 0)
// and the loader/debug master (port 1). Define MEM_ARB_RR_EN for round-robin ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_t        state, state_nxt;
  logic          owner, owner_nxt;
  logic          last;
  logic          in_access;
  logic [1:0]    mask;
  logic          win, win_vld;
  logic          own_we;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] own_wdata;
  logic [1:0]    rvalid_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

  assign in_access = (state == ACCESS);
  // The port being served this cycle still shows req, so it is kept out of the next pick.
  assign mask      = in_access ? (2'b01 << owner) : 2'b00;

  assign own_we    = (owner == PORT_DBG) ? m1_we    : m0_we;
  assign own_addr  = (owner == PORT_DBG) ? m1_addr  : m0_addr;
  assign own_wdata = (owner == PORT_DBG) ? m1_wdata : m0_wdata;

  arb_pick u_pick (
    .req    ({m1_req, m0_req}),
    .mask   (mask),
    .last   (last),
    .winner (win),
    .valid  (win_vld)
  );

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= PORT_DBG;
    end else if (in_access) begin
      last <= owner;
    end
  end
`else
  // Fixed priority: "last granted" pinned to port 1 makes every tie go to port 0.
  assign last = PORT_DBG;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= PORT_CPU;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // With the exclusion mask, IDLE and ACCESS share one transition rule.
  always_comb begin
    state_nxt = IDLE;
    owner_nxt = owner;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = m0_addr;
    mem_wdata = '0;
    if (win_vld) begin
      state_nxt = ACCESS;
      owner_nxt = win;
    end
    if (in_access) begin
      // A cycle under reset issues nothing, so neither write nor grant escapes.
      m0_gnt    = (owner == PORT_CPU) && !rst;
      m1_gnt    = (owner == PORT_DBG) && !rst;
      mem_we    = own_we && !rst;
      mem_addr  = own_addr;
      mem_wdata = own_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvalid_q <= '0;
      if (in_access && !own_we) begin
        rvalid_q[owner] <= 1'b1;
      end
      if (rvalid_q[0]) rdata0_q <= mem_rdata;
      if (rvalid_q[1]) rdata1_q <= mem_rdata;
    end
  end

  // Memory data arrives in the rvalid cycle; the registers hold it afterwards.
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = rvalid_q[0] ? mem_rdata : rdata0_q;
  assign m1_rdata  = rvalid_q[1] ? mem_rdata : rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req, we;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we;
  logic [DW-1:0] m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (req[0]),
    .m0_we     (we[0]),
    .m0_addr   (addr[0]),
    .m0_wdata  (wdata[0]),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (req[1]),
    .m1_we     (we[1]),
    .m1_addr   (addr[1]),
    .m1_wdata  (wdata[1]),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory, 256 words.
  logic [DW-1:0] mem [256] = '{default: '0};
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:2]];
  end

  // Reference model: who is served this cycle, which read returns now, memory image.
  logic [1:0]    m_gnt;
  logic [1:0]    m_rv;
  logic [DW-1:0] m_rdata [2];
  logic          m_last;
  logic [DW-1:0] ref_mem [256] = '{default: '0};
  bit            m_ok = 1'b0;

  logic [1:0]    seen_gnt, seen_rv;
  logic          seen_we;
  logic [DW-1:0] seen_rdata [2];
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a      = '0;
    a[9:2] = 8'($urandom_range(0, 255));
    return a;
  endfunction

  task automatic sample_and_check();
    int            p;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    seen_gnt      = {m1_gnt, m0_gnt};
    seen_rv       = {m1_rvalid, m0_rvalid};
    seen_we       = mem_we;
    seen_rdata[0] = m0_rdata;
    seen_rdata[1] = m1_rdata;
    if (rst) check("mem_we_in_rst", mem_we, 0);
    if (m_ok) begin
      e_we    = 1'b0;
      e_addr  = addr[0];
      e_wdata = '0;
      if (m_gnt != 2'b00) begin
        p       = m_gnt[1] ? 1 : 0;
        e_we    = we[p] && !rst;
        e_addr  = addr[p];
        e_wdata = wdata[p];
      end
      check("gnt", seen_gnt, rst ? 2'b00 : m_gnt);
      check("rvalid", seen_rv, m_rv);
      check("m0_rdata", seen_rdata[0], m_rdata[0]);
      check("m1_rdata", seen_rdata[1], m_rdata[1]);
      check("mem_we", mem_we, e_we);
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata", mem_wdata, e_wdata);
    end
  endtask

  task automatic model_advance();
    int         p;
    logic [1:0] ng;
    if (rst) begin
      m_gnt      = 2'b00;
      m_rv       = 2'b00;
      m_rdata[0] = '0;
      m_rdata[1] = '0;
      m_last     = 1'b1;
      m_ok       = 1'b1;
    end else if (m_ok) begin
      m_rv = 2'b00;
      if (m_gnt != 2'b00) begin
        p = m_gnt[1] ? 1 : 0;
        if (we[p]) ref_mem[addr[p][9:2]] = wdata[p];
        else begin
          m_rv[p]    = 1'b1;
          m_rdata[p] = ref_mem[addr[p][9:2]];
        end
        m_last = (p == 1);
        // Only the other port may be served back-to-back.
        ng = req[1-p] ? (2'b01 << (1 - p)) : 2'b00;
      end else if (req == 2'b11) begin
`ifdef MEM_ARB_RR_EN
        ng = m_last ? 2'b01 : 2'b10;
`else
        ng = 2'b01;
`endif
      end else begin
        ng = req;
      end
      m_gnt = ng;
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    sample_and_check();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic new_access(input int p);
    req[p]   = 1'b1;
    we[p]    = 1'($urandom_range(0, 1));
    addr[p]  = rand_addr();
    wdata[p] = $urandom;
  endtask

  // Issue one access on port p, return cycles from req to gnt, then run the rvalid cycle.
  task automatic do_access(input int p, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, output int lat);
    int n;
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
    n = 0;
    do begin
      run_cycle();
      n++;
    end while (!seen_gnt[p] && n < 10);
    check("gnt_within_bound", seen_gnt[p], 1);
    lat    = n - 1;
    req[p] = 1'b0;
    run_cycle();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   lat, n;
    logic first;

    // Reset held with a pending port 0 write.
    rst = 1'b1; req = 2'b01; we = 2'b01;
    addr[0] = '0; addr[1] = '0; wdata[0] = 32'h1234; wdata[1] = '0;
    repeat (3) run_cycle();
    rst = 1'b0;
    run_cycle();
    check("rst_gnt", seen_gnt, 0);
    check("rst_rvalid", seen_rv, 0);
    check("rst_rdata0", seen_rdata[0], 0);
    check("rst_rdata1", seen_rdata[1], 0);
    check("rst_mem_we", seen_we, 0);
    run_cycle();
    check("post_rst_gnt", seen_gnt, 2'b01);
    req[0] = 1'b0;
    run_cycle();

    // Single read after a debug-port write.
    do_access(1, 1'b1, 32'h40, 32'hDEADBEEF, lat);
    do_access(0, 1'b0, 32'h40, '0, lat);
    check("rd_gnt_latency", lat, 1);
    check("rd_rvalid", seen_rv[0], 1);
    check("rd_data", seen_rdata[0], 32'hDEADBEEF);

    // Ties from IDLE, four times.
    for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARB_RR_EN
      first = ~m_last;
`else
      first = 1'b0;
`endif
      req = 2'b11; we = 2'b00; addr[0] = rand_addr(); addr[1] = rand_addr();
      run_cycle();
      check("tie_idle", seen_gnt, 0);
      run_cycle();
      check("tie_first", seen_gnt, 2'b01 << first);
      req[first] = 1'b0;
      run_cycle();
      check("tie_second", seen_gnt, 2'b01 << !first);
      check("tie_rv_first", seen_rv, 2'b01 << first);
      req[!first] = 1'b0;
      run_cycle();
      check("tie_rv_second", seen_rv, 2'b01 << !first);
    end

    // Continuous port 0 traffic must not starve port 1.
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = rand_addr();
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      if (seen_gnt[0]) addr[0] = rand_addr();
    end
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h80; wdata[1] = 32'h100;
    n = 0;
    do begin
      run_cycle();
      n++;
      if (seen_gnt[0]) addr[0] = rand_addr();
    end while (!seen_gnt[1] && n < 10);
    check("m1_no_starve", (n - 1 <= 2), 1);
    req[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_cycle();
      if (seen_gnt[0]) addr[0] = rand_addr();
    end
    req[0] = 1'b0;
    run_cycle();
    run_cycle();
    do_access(0, 1'b0, 32'h80, '0, lat);
    check("cont_rd_data", seen_rdata[0], 32'h100);

    // Reset during the ACCESS cycle of a port 1 write.
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h84; wdata[1] = 32'h55AA;
    run_cycle();
    check("mid_rst_idle", seen_gnt, 0);
    rst = 1'b1; req[1] = 1'b0;
    run_cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      check("mid_rst_no_gnt", seen_gnt, 0);
      check("mid_rst_no_rv", seen_rv, 0);
    end
    do_access(0, 1'b0, 32'h84, '0, lat);
    check("mid_rst_mem", seen_rdata[0], 0);

    // Random traffic with occasional reset.
    for (int c = 0; c < 3000; c++) begin
      run_cycle();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        req = 2'b00;
      end
      if (!rst) begin
        for (int p = 0; p < 2; p++) begin
          if (req[p] && seen_gnt[p]) begin
            if ($urandom_range(0, 1) == 1) new_access(p);
            else req[p] = 1'b0;
          end else if (!req[p] && $urandom_range(0, 2) == 0) begin
            new_access(p);
          end
        end
      end
    end
    req = 2'b00;
    run_cycle();
    run_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
